pwm_apb_regs: RTL and testbench
===============================

# pwm_apb_regs

APB3 slave register bank that drives the configuration inputs of the two-channel PWM core (prescaler, auto-reload, per-channel start/end compares, dead-time, channel config, counter enable). Sits directly upstream of the PWM core on the same clock. Provides a key-sequence write lock that protects timing registers from stray writes once the PWM is armed.

## Interface
- WIDTH, 16: counter/compare/config field width (1..32)
- clk_psc_i  in  1  clock shared with the PWM core
- rst_n_i  in  1  asynchronous active-low reset
- psel_i, penable_i, pwrite_i  in  1 each  APB3 controls
- paddr_i  in  6  byte address, bits [1:0] ignored
- pwdata_i  in  32  write data
- prdata_o  out  32  read data, registered
- pready_o  out  1  registered, one wait state
- pslverr_o  out  1  registered, valid with pready_o
- cnt_en_o  out  1  CTRL.CEN
- psc_preload_o, arr_preload_o  out  WIDTH each
- cmp_ch1_start_o, cmp_ch1_end_o, cmp_ch2_start_o, cmp_ch2_end_o  out  WIDTH each
- dtg_ch1_o, dtg_ch2_o  out  8 each
- cfg_reg_ch1_o, cfg_reg_ch2_o  out  WIDTH each
- locked_o  out  1  lock FSM not in UNLOCKED

## Operation
- Map (offset: field, reset): 0x00 CTRL [0]=CEN RW, [1]=LOCKED RO, 0; 0x04 PSC, 0; 0x08 ARR, all ones; 0x0C CH1_START, 0; 0x10 CH1_END, 0; 0x14 CH2_START, 0; 0x18 CH2_END, 0; 0x1C DTG [7:0]=ch1 [15:8]=ch2, 0; 0x20 CFG1, 0; 0x24 CFG2, 0; 0x28 KEY, WO, reads 0.
- WIDTH fields take pwdata_i[WIDTH-1:0]; reads zero-extend to 32 bits.
- Unmapped offset (0x2C-0x3C): write ignored, read 0, pslverr_o=1.
- Lock FSM: UNLOCKED -(KEY write 0xC3)-> LOCKED; LOCKED -(KEY write 0x5A)-> KEY1; KEY1 -(KEY write 0xA5)-> UNLOCKED; KEY1 -(any other write, any address)-> LOCKED. Other KEY values ignored, no error. Reads never move the FSM. Only pwdata_i[7:0] compared; upper bits ignored.
- While locked (LOCKED or KEY1): writes to 0x04-0x24 ignored and pslverr_o=1; CTRL and KEY writes accepted; reads unaffected.
- All outputs driven straight from flops; reset values as in map, pready_o=0, pslverr_o=0, prdata_o=0, locked_o=0.

## Timing
- Bus FSM: IDLE, RESP. IDLE with psel_i&penable_i -> RESP at next edge; RESP -> IDLE unconditionally.
- Setup cycle T, access T+1 (pready_o=0), T+2 pready_o=1 with prdata_o/pslverr_o valid. Every transfer completes in exactly 3 cycles.
- Write commit and lock transition occur on the edge ending T+1; outputs show the new value in T+2, concurrent with pready_o.
- Read data sampled on the same edge: a read reflects all writes completed before it.
- psel_i dropped before penable_i: no transfer, no state change.
- Back-to-back: new setup phase allowed in the RESP cycle; next access enters IDLE->RESP normally.
- Async reset mid-transfer: all state to reset values immediately; the interrupted transfer is lost, pready_o stays 0 until a new access.

## Structure
- Package pwm_reg_pkg: offset localparams, KEY_LOCK=8'hC3, KEY_UNLK1=8'h5A, KEY_UNLK2=8'hA5, ARR reset value, lock-state enum (2-bit).
- Sub-module pwm_lock_fsm: inputs key write strobe, any-write strobe, data[7:0]; output locked. Decode, register bank, read mux in top.

## Test plan
- Reset -> ARR reads 0x0000FFFF, all others 0, pready_o=0, locked_o=0, cnt_en_o=0.
- Write PSC=0x0007 -> pready_o high exactly T+2, psc_preload_o=0x0007 in T+2, readback 0x00000007, pslverr_o=0.
- Read 0x30 / write 0x3C -> prdata_o=0, pslverr_o=1, no output changes.
- KEY=0xC3, then write ARR=0x0100 -> pslverr_o=1, arr unchanged, locked_o=1; write CTRL=1 -> cnt_en_o=1, no error.
- KEY 0x5A, CH1_START write, KEY 0xA5 -> still LOCKED; KEY 0x5A, KEY 0xA5 -> locked_o=0, ARR=0x0100 accepted.
- Assert rst_n_i during access cycle of a DTG write -> dtg outputs 0, pready_o never rises for that transfer.

Source files
------------

// File: rtl/pwm_reg_pkg.sv
// pwm_reg_pkg: shared definitions for the PWM APB register bank.
//   - byte offsets of every register in the 64-byte window
//   - key bytes for the write-lock sequence
//   - ARR reset value (truncated to WIDTH at the point of use)
//   - lock-state and bus-state enums
package pwm_reg_pkg;

  localparam logic [5:0] OFF_CTRL      = 6'h00;
  localparam logic [5:0] OFF_PSC       = 6'h04;
  localparam logic [5:0] OFF_ARR       = 6'h08;
  localparam logic [5:0] OFF_CH1_START = 6'h0C;
  localparam logic [5:0] OFF_CH1_END   = 6'h10;
  localparam logic [5:0] OFF_CH2_START = 6'h14;
  localparam logic [5:0] OFF_CH2_END   = 6'h18;
  localparam logic [5:0] OFF_DTG       = 6'h1C;
  localparam logic [5:0] OFF_CFG1      = 6'h20;
  localparam logic [5:0] OFF_CFG2      = 6'h24;
  localparam logic [5:0] OFF_KEY       = 6'h28;

  localparam logic [7:0] KEY_LOCK  = 8'hC3;
  localparam logic [7:0] KEY_UNLK1 = 8'h5A;
  localparam logic [7:0] KEY_UNLK2 = 8'hA5;

  localparam logic [31:0] ARR_RST = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    LK_UNLOCKED = 2'd0,
    LK_LOCKED   = 2'd1,
    LK_KEY1     = 2'd2
  } lock_state_e;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_RESP = 1'b1
  } bus_state_e;

endpackage

// File: rtl/pwm_lock_fsm.sv
// pwm_lock_fsm: key-sequence write lock.
//   clk_i, rst_n_i : clock, async active-low reset
//   key_wr_i       : committed write to the KEY register this cycle
//   any_wr_i       : committed write to any address this cycle
//   data_i         : low byte of the write data
//   locked_o       : registered, high whenever the state is not UNLOCKED
module pwm_lock_fsm
  import pwm_reg_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       key_wr_i,
  input  logic       any_wr_i,
  input  logic [7:0] data_i,
  output logic       locked_o
);

  lock_state_e state_q, state_d;
  logic        locked_q, locked_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LK_UNLOCKED: if (key_wr_i && data_i == KEY_LOCK)  state_d = LK_LOCKED;
      LK_LOCKED:   if (key_wr_i && data_i == KEY_UNLK1) state_d = LK_KEY1;
      // The second unlock byte must be the very next write, to any address.
      LK_KEY1:     if (any_wr_i) state_d = (key_wr_i && data_i == KEY_UNLK2) ? LK_UNLOCKED : LK_LOCKED;
      default:     state_d = LK_UNLOCKED;
    endcase
    locked_d = (state_d != LK_UNLOCKED);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= LK_UNLOCKED;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      locked_q <= locked_d;
    end
  end

  assign locked_o = locked_q;

endmodule

// File: rtl/pwm_apb_regs.sv
// pwm_apb_regs: APB3 register bank feeding the two-channel PWM core.
//   clk_psc_i, rst_n_i              : clock shared with PWM core, async active-low reset
//   psel_i/penable_i/pwrite_i       : APB3 controls; paddr_i byte address, [1:0] ignored
//   pwdata_i / prdata_o             : write data / registered read data
//   pready_o / pslverr_o            : registered, one wait state per transfer
//   cnt_en_o .. cfg_reg_ch2_o       : PWM core configuration, straight from flops
//   locked_o                        : timing registers write-protected
module pwm_apb_regs
  import pwm_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_psc_i,
  input  logic             rst_n_i,
  input  logic             psel_i,
  input  logic             penable_i,
  input  logic             pwrite_i,
  input  logic [5:0]       paddr_i,
  input  logic [31:0]      pwdata_i,
  output logic [31:0]      prdata_o,
  output logic             pready_o,
  output logic             pslverr_o,
  output logic             cnt_en_o,
  output logic [WIDTH-1:0] psc_preload_o,
  output logic [WIDTH-1:0] arr_preload_o,
  output logic [WIDTH-1:0] cmp_ch1_start_o,
  output logic [WIDTH-1:0] cmp_ch1_end_o,
  output logic [WIDTH-1:0] cmp_ch2_start_o,
  output logic [WIDTH-1:0] cmp_ch2_end_o,
  output logic [7:0]       dtg_ch1_o,
  output logic [7:0]       dtg_ch2_o,
  output logic [WIDTH-1:0] cfg_reg_ch1_o,
  output logic [WIDTH-1:0] cfg_reg_ch2_o,
  output logic             locked_o
);

  bus_state_e       bus_q, bus_d;
  logic             pready_q, pready_d, pslverr_q, pslverr_d;
  logic [31:0]      prdata_q, prdata_d;
  logic             cen_q, cen_d;
  logic [WIDTH-1:0] psc_q, psc_d, arr_q, arr_d;
  logic [WIDTH-1:0] c1s_q, c1s_d, c1e_q, c1e_d, c2s_q, c2s_d, c2e_q, c2e_d;
  logic [7:0]       dtg1_q, dtg1_d, dtg2_q, dtg2_d;
  logic [WIDTH-1:0] cfg1_q, cfg1_d, cfg2_q, cfg2_d;

  logic [5:0]  word_addr;
  logic        access, mapped, prot, err, wr_ok, locked;
  logic [31:0] rdata;
  logic        unused_bits;

  assign word_addr   = {paddr_i[5:2], 2'b00};
  // Byte-lane address bits and data bits above the widest field are don't-care.
  assign unused_bits = ^{paddr_i[1:0], pwdata_i};
  // An access phase only counts from IDLE; a lingering penable in RESP is ignored.
  assign access      = (bus_q == BUS_IDLE) && psel_i && penable_i;

  always_comb begin
    mapped = 1'b1;
    prot   = 1'b0;
    rdata  = '0;
    case (word_addr)
      OFF_CTRL:      rdata = {30'd0, locked, cen_q};
      OFF_PSC:       begin prot = 1'b1; rdata = 32'(psc_q);  end
      OFF_ARR:       begin prot = 1'b1; rdata = 32'(arr_q);  end
      OFF_CH1_START: begin prot = 1'b1; rdata = 32'(c1s_q);  end
      OFF_CH1_END:   begin prot = 1'b1; rdata = 32'(c1e_q);  end
      OFF_CH2_START: begin prot = 1'b1; rdata = 32'(c2s_q);  end
      OFF_CH2_END:   begin prot = 1'b1; rdata = 32'(c2e_q);  end
      OFF_DTG:       begin prot = 1'b1; rdata = {16'd0, dtg2_q, dtg1_q}; end
      OFF_CFG1:      begin prot = 1'b1; rdata = 32'(cfg1_q); end
      OFF_CFG2:      begin prot = 1'b1; rdata = 32'(cfg2_q); end
      OFF_KEY:       rdata = '0;
      default:       mapped = 1'b0;
    endcase
  end

  assign err   = !mapped || (pwrite_i && prot && locked);
  assign wr_ok = access && pwrite_i && !err;

  always_comb begin
    cen_d  = cen_q;  psc_d  = psc_q;  arr_d  = arr_q;
    c1s_d  = c1s_q;  c1e_d  = c1e_q;  c2s_d  = c2s_q;  c2e_d = c2e_q;
    dtg1_d = dtg1_q; dtg2_d = dtg2_q; cfg1_d = cfg1_q; cfg2_d = cfg2_q;
    if (wr_ok) begin
      case (word_addr)
        OFF_CTRL:      cen_d = pwdata_i[0];
        OFF_PSC:       psc_d = pwdata_i[WIDTH-1:0];
        OFF_ARR:       arr_d = pwdata_i[WIDTH-1:0];
        OFF_CH1_START: c1s_d = pwdata_i[WIDTH-1:0];
        OFF_CH1_END:   c1e_d = pwdata_i[WIDTH-1:0];
        OFF_CH2_START: c2s_d = pwdata_i[WIDTH-1:0];
        OFF_CH2_END:   c2e_d = pwdata_i[WIDTH-1:0];
        OFF_DTG:       begin dtg1_d = pwdata_i[7:0]; dtg2_d = pwdata_i[15:8]; end
        OFF_CFG1:      cfg1_d = pwdata_i[WIDTH-1:0];
        OFF_CFG2:      cfg2_d = pwdata_i[WIDTH-1:0];
        default:       ;
      endcase
    end

    bus_d = BUS_IDLE;
    unique case (bus_q)
      BUS_IDLE: if (access) bus_d = BUS_RESP;
      BUS_RESP: bus_d = BUS_IDLE;
      default:  bus_d = BUS_IDLE;
    endcase

    pready_d  = access;
    pslverr_d = access && err;
    prdata_d  = (access && !pwrite_i) ? rdata : '0;
  end

  always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bus_q    <= BUS_IDLE;
      pready_q <= 1'b0;  pslverr_q <= 1'b0;  prdata_q <= '0;
      cen_q    <= 1'b0;  psc_q     <= '0;    arr_q    <= ARR_RST[WIDTH-1:0];
      c1s_q    <= '0;    c1e_q     <= '0;    c2s_q    <= '0;  c2e_q <= '0;
      dtg1_q   <= '0;    dtg2_q    <= '0;    cfg1_q   <= '0;  cfg2_q <= '0;
    end else begin
      bus_q    <= bus_d;
      pready_q <= pready_d;  pslverr_q <= pslverr_d;  prdata_q <= prdata_d;
      cen_q    <= cen_d;     psc_q     <= psc_d;      arr_q    <= arr_d;
      c1s_q    <= c1s_d;     c1e_q     <= c1e_d;      c2s_q    <= c2s_d;  c2e_q <= c2e_d;
      dtg1_q   <= dtg1_d;    dtg2_q    <= dtg2_d;     cfg1_q   <= cfg1_d; cfg2_q <= cfg2_d;
    end
  end

  pwm_lock_fsm u_lock (
    .clk_i    (clk_psc_i),
    .rst_n_i  (rst_n_i),
    .key_wr_i (access && pwrite_i && (word_addr == OFF_KEY)),
    .any_wr_i (access && pwrite_i),
    .data_i   (pwdata_i[7:0]),
    .locked_o (locked)
  );

  assign prdata_o        = prdata_q;
  assign pready_o        = pready_q;
  assign pslverr_o       = pslverr_q;
  assign cnt_en_o        = cen_q;
  assign psc_preload_o   = psc_q;
  assign arr_preload_o   = arr_q;
  assign cmp_ch1_start_o = c1s_q;
  assign cmp_ch1_end_o   = c1e_q;
  assign cmp_ch2_start_o = c2s_q;
  assign cmp_ch2_end_o   = c2e_q;
  assign dtg_ch1_o       = dtg1_q;
  assign dtg_ch2_o       = dtg2_q;
  assign cfg_reg_ch1_o   = cfg1_q;
  assign cfg_reg_ch2_o   = cfg2_q;
  assign locked_o        = locked;

endmodule

// File: tb/tb_pwm_apb_regs.sv
// tb_pwm_apb_regs: self-checking bench for pwm_apb_regs (WIDTH=16).
// Directed vector table, hand-written corner sequences and a randomized
// phase, all checked against a register-array/lock-state reference model.
module tb_pwm_apb_regs;
  localparam int unsigned WIDTH = 16;
  localparam logic [31:0] WMASK = 32'h0000_FFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [5:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic pready, pslverr, cnt_en, locked;
  logic [WIDTH-1:0] psc, arr, c1s, c1e, c2s, c2e, cfg1, cfg2;
  logic [7:0] dtg1, dtg2;

  always #5 clk = ~clk;

  pwm_apb_regs #(.WIDTH(WIDTH)) dut (
    .clk_psc_i(clk), .rst_n_i(rst_n),
    .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata),
    .prdata_o(prdata), .pready_o(pready), .pslverr_o(pslverr),
    .cnt_en_o(cnt_en), .psc_preload_o(psc), .arr_preload_o(arr),
    .cmp_ch1_start_o(c1s), .cmp_ch1_end_o(c1e),
    .cmp_ch2_start_o(c2s), .cmp_ch2_end_o(c2e),
    .dtg_ch1_o(dtg1), .dtg_ch2_o(dtg2),
    .cfg_reg_ch1_o(cfg1), .cfg_reg_ch2_o(cfg2),
    .locked_o(locked)
  );

  int total = 0;
  int bad = 0;

  // Reference model: one 32-bit word per register index, lock stage 0/1/2.
  logic [31:0] m_reg [0:10];
  int m_lock;

  typedef struct {
    bit          wr;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    bit          exp_err;
    bit          exp_lk;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i <= 10; i++) m_reg[i] = '0;
    m_reg[2] = WMASK;
    m_lock = 0;
  endtask

  task automatic model_xfer(input bit wr, input logic [5:0] addr, input logic [31:0] data,
                            output logic [31:0] rd, output logic err);
    int unsigned idx;
    idx = 32'(addr[5:2]);
    rd = '0;
    err = 1'b0;
    if (idx > 10) err = 1'b1;
    else if (!wr) rd = (idx == 0) ? {30'd0, (m_lock != 0), m_reg[0][0]} : m_reg[idx];
    else if (idx >= 1 && idx <= 9 && m_lock != 0) err = 1'b1;
    else if (idx == 0) m_reg[0] = {31'd0, data[0]};
    else if (idx == 7) m_reg[7] = data & 32'h0000_FFFF;
    else if (idx != 10) m_reg[idx] = data & WMASK;
    if (wr) begin
      case (m_lock)
        0: if (idx == 10 && data[7:0] == 8'hC3) m_lock = 1;
        1: if (idx == 10 && data[7:0] == 8'h5A) m_lock = 2;
        default: m_lock = (idx == 10 && data[7:0] == 8'hA5) ? 0 : 1;
      endcase
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".cnt_en"}, 32'(cnt_en), 32'(m_reg[0][0]));
    chk({tag, ".psc"},    32'(psc),    m_reg[1]);
    chk({tag, ".arr"},    32'(arr),    m_reg[2]);
    chk({tag, ".c1s"},    32'(c1s),    m_reg[3]);
    chk({tag, ".c1e"},    32'(c1e),    m_reg[4]);
    chk({tag, ".c2s"},    32'(c2s),    m_reg[5]);
    chk({tag, ".c2e"},    32'(c2e),    m_reg[6]);
    chk({tag, ".dtg1"},   32'(dtg1),   32'(m_reg[7][7:0]));
    chk({tag, ".dtg2"},   32'(dtg2),   32'(m_reg[7][15:8]));
    chk({tag, ".cfg1"},   32'(cfg1),   m_reg[8]);
    chk({tag, ".cfg2"},   32'(cfg2),   m_reg[9]);
    chk({tag, ".locked"}, 32'(locked), 32'(m_lock != 0));
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that ends T+1,
  // i.e. inside the response cycle, leaving the bus free for a new setup.
  task automatic apb(input bit wr, input logic [5:0] addr, input logic [31:0] data,
                     output logic [31:0] rd, output logic err);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    @(posedge clk); #1;
    penable = 1'b1;
    chk("pready_in_access", 32'(pready), 32'd0);
    @(posedge clk); #1;
    chk("pready_in_resp", 32'(pready), 32'd1);
    rd = prdata;
    err = pslverr;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic apb_model(input bit wr, input logic [5:0] addr, input logic [31:0] data);
    logic [31:0] rd, mrd;
    logic err, merr;
    apb(wr, addr, data, rd, err);
    model_xfer(wr, addr, data, mrd, merr);
    if (!wr) chk("rnd.prdata", rd, mrd);
    chk("rnd.pslverr", 32'(err), 32'(merr));
    chk_outputs("rnd");
  endtask

  task automatic add_vec(input bit wr, input logic [5:0] a, input logic [31:0] d,
                         input logic [31:0] r, input bit e, input bit l);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.exp_rd = r; v.exp_err = e; v.exp_lk = l;
    vt.push_back(v);
  endtask

  task automatic do_reset();
    psel = 1'b0; penable = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, mrd;
    logic err, merr;

    // wr, addr, data, expected read, expected pslverr, expected locked
    add_vec(0, 6'h08, 32'h0,        32'h0000_FFFF, 0, 0);
    add_vec(0, 6'h00, 32'h0,        32'h0,         0, 0);
    add_vec(1, 6'h04, 32'h0000_0007, 32'h0,        0, 0);
    add_vec(0, 6'h04, 32'h0,        32'h0000_0007, 0, 0);
    add_vec(0, 6'h30, 32'h0,        32'h0,         1, 0);
    add_vec(1, 6'h3C, 32'hFFFF_FFFF, 32'h0,        1, 0);
    add_vec(0, 6'h3C, 32'h0,        32'h0,         1, 0);
    add_vec(1, 6'h28, 32'h0000_00C3, 32'h0,        0, 1);
    add_vec(1, 6'h08, 32'h0000_0100, 32'h0,        1, 1);
    add_vec(0, 6'h08, 32'h0,        32'h0000_FFFF, 0, 1);
    add_vec(1, 6'h00, 32'h0000_0001, 32'h0,        0, 1);
    add_vec(0, 6'h00, 32'h0,        32'h0000_0003, 0, 1);
    add_vec(1, 6'h28, 32'h0000_005A, 32'h0,        0, 1);
    add_vec(1, 6'h0C, 32'h0000_0055, 32'h0,        1, 1);
    add_vec(1, 6'h28, 32'h0000_00A5, 32'h0,        0, 1);
    add_vec(0, 6'h0C, 32'h0,        32'h0,         0, 1);
    add_vec(1, 6'h28, 32'h0000_005A, 32'h0,        0, 1);
    add_vec(1, 6'h28, 32'hFFFF_FFA5, 32'h0,        0, 0);
    add_vec(1, 6'h08, 32'h0000_0100, 32'h0,        0, 0);
    add_vec(0, 6'h08, 32'h0,        32'h0000_0100, 0, 0);
    add_vec(0, 6'h28, 32'h0,        32'h0,         0, 0);
    add_vec(0, 6'h00, 32'h0,        32'h0000_0001, 0, 0);
    add_vec(1, 6'h1C, 32'hFFFF_1234, 32'h0,        0, 0);
    add_vec(0, 6'h1C, 32'h0,        32'h0000_1234, 0, 0);
    add_vec(1, 6'h20, 32'hABCD_0001, 32'h0,        0, 0);
    add_vec(0, 6'h20, 32'h0,        32'h0000_0001, 0, 0);
    add_vec(1, 6'h28, 32'h0000_0011, 32'h0,        0, 0);
    add_vec(1, 6'h28, 32'h0000_00C3, 32'h0,        0, 1);
    add_vec(1, 6'h28, 32'h0000_005A, 32'h0,        0, 1);
    add_vec(0, 6'h28, 32'h0,        32'h0,         0, 1);
    add_vec(1, 6'h3C, 32'h0,        32'h0,         1, 1);
    add_vec(1, 6'h28, 32'h0000_00A5, 32'h0,        0, 1);
    add_vec(0, 6'h00, 32'h0,        32'h0000_0003, 0, 1);
    add_vec(1, 6'h28, 32'h0000_005A, 32'h0,        0, 1);
    add_vec(1, 6'h28, 32'h0000_00A5, 32'h0,        0, 0);

    do_reset();
    chk("reset.pready",  32'(pready),  32'd0);
    chk("reset.pslverr", 32'(pslverr), 32'd0);
    chk("reset.prdata",  prdata,       32'd0);
    chk_outputs("reset");

    foreach (vt[i]) begin
      apb(vt[i].wr, vt[i].addr, vt[i].data, rd, err);
      model_xfer(vt[i].wr, vt[i].addr, vt[i].data, mrd, merr);
      if (!vt[i].wr) chk($sformatf("vec%0d.prdata", i), rd, vt[i].exp_rd);
      chk($sformatf("vec%0d.pslverr", i), 32'(err), 32'(vt[i].exp_err));
      chk($sformatf("vec%0d.locked", i), 32'(locked), 32'(vt[i].exp_lk));
      chk_outputs($sformatf("vec%0d", i));
    end

    // Setup phase abandoned (psel drops before penable): nothing may happen.
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 6'h04; pwdata = 32'h99;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b1;
    @(posedge clk); #1;
    chk("abort.pready1", 32'(pready), 32'd0);
    penable = 1'b0;
    @(posedge clk); #1;
    chk("abort.pready2", 32'(pready), 32'd0);
    chk_outputs("abort");

    // Randomized back-to-back and gapped transfers.
    for (int n = 0; n < 400; n++) begin
      logic [3:0] w;
      logic [1:0] lane;
      logic [31:0] d;
      bit wr;
      w = 4'($urandom_range(0, 15));
      lane = 2'($urandom_range(0, 3));
      wr = 1'($urandom_range(0, 1));
      d = $urandom;
      if (w == 4'd10) begin
        case ($urandom_range(0, 3))
          0: d[7:0] = 8'hC3;
          1: d[7:0] = 8'h5A;
          2: d[7:0] = 8'hA5;
          default: ;
        endcase
        wr = ($urandom_range(0, 4) != 0);
      end
      apb_model(wr, {w, lane}, d);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk); #1;
        end
      end
    end

    // Async reset during the access cycle of a DTG write.
    do_reset();
    apb_model(1'b1, 6'h1C, 32'h0000_1234);
    chk("pre_rst.dtg1", 32'(dtg1), 32'h34);
    chk("pre_rst.dtg2", 32'(dtg2), 32'h12);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 6'h1C; pwdata = 32'h0000_ABCD;
    @(posedge clk); #1;
    penable = 1'b1;
    #2;
    rst_n = 1'b0;
    psel = 1'b0; penable = 1'b0;
    #1;
    chk("midrst.dtg1",   32'(dtg1),   32'h0);
    chk("midrst.dtg2",   32'(dtg2),   32'h0);
    chk("midrst.pready", 32'(pready), 32'h0);
    chk("midrst.arr",    32'(arr),    32'h0000_FFFF);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("postrst.pready", 32'(pready), 32'd0);
    end
    chk_outputs("postrst");
    apb_model(1'b0, 6'h1C, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
